// File: rtl/egress_request_sequencer.sv
// Turns one 2-D fetch job into one 128-bit read command per row, credit-limited by row completions.
// Optional build macro EGRESS_REQ_SEQ_ERR_CHECK_EN enables the sticky protocol error flag.
module egress_request_sequencer #(
  parameter int C_PACKET_WIDTH    = 128,
  parameter int C_MAX_OUTSTANDING = 4,
  parameter int C_ROW_CNT_WIDTH   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_accept,
  input  logic [63:0]                job_base_addr,
  input  logic [35:0]                job_row_len,
  input  logic [35:0]                job_row_stride,
  input  logic [C_ROW_CNT_WIDTH-1:0] job_row_count,
  input  logic [7:0]                 job_id,
  output logic                       cmd_valid,
  input  logic                       cmd_accept,
  output logic [C_PACKET_WIDTH-1:0]  cmd_payload,
  input  logic                       row_done,
  output logic                       job_busy,
  output logic                       job_done,
  output logic                       error
);

  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_DRAIN = 3'b100
  } state_e;

  state_e                     state_q;
  logic                       rdy_q;
  logic [63:0]                addr_q;
  logic [35:0]                len_q;
  logic [35:0]                stride_q;
  logic [C_ROW_CNT_WIDTH-1:0] count_q;
  logic [C_ROW_CNT_WIDTH-1:0] row_idx_q;
  logic [7:0]                 id_q;
  logic [7:0]                 op_q;
  logic [OW-1:0]              out_q;
  logic [OW-1:0]              out_d;
  logic                       done_q;
  logic                       fire;
  logic                       rd_cnt;
  logic                       last_row;
  logic [11:0]                row_idx_pkt;

  // rdy_q keeps job_accept low while rst is held, even though state is already IDLE.
  assign job_accept = (state_q == ST_IDLE) & rdy_q;
  assign cmd_valid  = (state_q == ST_ISSUE) & (out_q < OW'(C_MAX_OUTSTANDING));
  assign fire       = cmd_valid & cmd_accept;
  assign rd_cnt     = row_done & (state_q != ST_IDLE);
  assign last_row   = (row_idx_q == count_q - C_ROW_CNT_WIDTH'(1));
  assign job_busy   = (state_q != ST_IDLE);
  assign job_done   = done_q;

  if (C_ROW_CNT_WIDTH >= 12) begin : g_idx_trunc
    assign row_idx_pkt = row_idx_q[11:0];
  end else begin : g_idx_pad
    assign row_idx_pkt = {{(12 - C_ROW_CNT_WIDTH){1'b0}}, row_idx_q};
  end

  // Opcode lives in a register so the whole packet reads zero out of reset.
  assign cmd_payload = {addr_q, len_q, row_idx_pkt, id_q, op_q};

  // Completions with nothing outstanding saturate at zero.
  always_comb begin
    out_d = out_q;
    if (fire && !rd_cnt)
      out_d = out_q + OW'(1);
    else if (!fire && rd_cnt && (out_q != '0))
      out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      stride_q  <= '0;
      count_q   <= '0;
      row_idx_q <= '0;
      id_q      <= '0;
      op_q      <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
      out_q  <= out_d;
      case (state_q)
        ST_IDLE: begin
          if (job_valid && job_accept) begin
            addr_q    <= job_base_addr;
            len_q     <= job_row_len;
            stride_q  <= job_row_stride;
            count_q   <= job_row_count;
            id_q      <= job_id;
            op_q      <= 8'h01;
            row_idx_q <= '0;
            state_q   <= (job_row_count != '0) ? ST_ISSUE : ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          if (fire) begin
            addr_q    <= addr_q + {28'd0, stride_q};
            row_idx_q <= row_idx_q + C_ROW_CNT_WIDTH'(1);
            if (last_row)
              state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_d == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef EGRESS_REQ_SEQ_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (row_done && ((state_q == ST_IDLE) || ((out_q == '0) && !fire)))
      err_q <= 1'b1;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_egress_request_sequencer.sv
// Randomized bench for egress_request_sequencer against a row-list / credit-count reference model.
module tb_egress_request_sequencer;

  localparam int MAX = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_accept;
  logic [63:0]  job_base_addr = '0;
  logic [35:0]  job_row_len = '0;
  logic [35:0]  job_row_stride = '0;
  logic [11:0]  job_row_count = '0;
  logic [7:0]   job_id = '0;
  logic         cmd_valid;
  logic         cmd_accept = 1'b0;
  logic [127:0] cmd_payload;
  logic         row_done = 1'b0;
  logic         job_busy;
  logic         job_done;
  logic         error;

  int total = 0;
  int bad = 0;
  int cyc = 0;

`ifdef EGRESS_REQ_SEQ_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  egress_request_sequencer #(
    .C_PACKET_WIDTH(128), .C_MAX_OUTSTANDING(MAX), .C_ROW_CNT_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_accept(job_accept),
    .job_base_addr(job_base_addr), .job_row_len(job_row_len),
    .job_row_stride(job_row_stride), .job_row_count(job_row_count), .job_id(job_id),
    .cmd_valid(cmd_valid), .cmd_accept(cmd_accept), .cmd_payload(cmd_payload),
    .row_done(row_done), .job_busy(job_busy), .job_done(job_done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one job to completion; every cycle compares against the reference model.
  task automatic run_job(input logic [63:0] base, input logic [35:0] len, input logic [35:0] stride,
                         input int count, input logic [7:0] id, input int acc_pct, input int dly,
                         input int hold, output int n_cmd, output int first_rd_cmds,
                         output int hs_cyc, output int done_cyc, output logic [63:0] last_addr);
    int issued, out_m, budget;
    bit active, done_exp, exp_valid, acc, fire, rd, in_drain, seen_rd;
    int due[$];
    logic [127:0] exp_pkt;
    n_cmd = 0; first_rd_cmds = -1; done_cyc = -1; last_addr = '0;
    @(negedge clk);
    total++;
    if (job_accept !== 1'b1) begin bad++; $display("FAIL job_accept_idle got=%b want=1", job_accept); end
    job_valid = 1'b1; job_base_addr = base; job_row_len = len; job_row_stride = stride;
    job_row_count = 12'(count); job_id = id;
    @(negedge clk);
    job_valid = 1'b0;
    hs_cyc = cyc;
    active = 1; issued = 0; out_m = 0; done_exp = 0; seen_rd = 0;
    for (budget = 0; budget < 3000; budget++) begin
      exp_valid = active && (issued < count) && (out_m < MAX);
      total++;
      if (cmd_valid !== exp_valid) begin
        bad++; $display("FAIL cmd_valid cyc=%0d got=%b want=%b", cyc, cmd_valid, exp_valid);
      end
      total++;
      if (job_done !== done_exp) begin
        bad++; $display("FAIL job_done cyc=%0d got=%b want=%b", cyc, job_done, done_exp);
      end
      total++;
      if (job_busy !== active || job_accept !== !active) begin
        bad++; $display("FAIL busy_accept cyc=%0d got=%b/%b want=%b/%b", cyc, job_busy, job_accept, active, !active);
      end
      if (exp_valid) begin
        exp_pkt = {base + {28'd0, stride} * 64'(issued), len, 12'(issued), id, 8'h01};
        total++;
        if (cmd_payload !== exp_pkt) begin
          bad++; $display("FAIL payload row=%0d got=%h want=%h", issued, cmd_payload, exp_pkt);
        end
      end
      if (done_exp) begin done_cyc = cyc; break; end
      acc = ($urandom_range(99) < acc_pct);
      cmd_accept = acc;
      fire = exp_valid && acc;
      rd = (due.size() > 0) && (due[0] <= cyc + 1) && (cyc + 1 >= hs_cyc + hold);
      row_done = rd;
      if (rd) begin
        void'(due.pop_front());
        if (!seen_rd) begin seen_rd = 1; first_rd_cmds = n_cmd; end
      end
      in_drain = (issued == count);
      if (fire) begin
        last_addr = cmd_payload[127:64];
        issued++; n_cmd++;
        due.push_back(cyc + 1 + dly);
      end
      out_m = out_m + int'(fire) - int'(rd);
      done_exp = in_drain && (out_m == 0);
      if (done_exp) active = 0;
      @(negedge clk);
    end
    if (budget >= 3000) begin bad++; total++; $display("FAIL job_timeout got=no_done want=done"); end
    cmd_accept = 1'b0; row_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({job_accept, cmd_valid, job_busy, job_done, error} !== 5'b0 || cmd_payload !== '0) begin
      bad++; $display("FAIL reset_state got=%b pl=%h want=00000 pl=0", {job_accept, cmd_valid, job_busy, job_done, error}, cmd_payload);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (job_accept !== 1'b1) begin bad++; $display("FAIL accept_after_reset got=%b want=1", job_accept); end
  endtask

  task automatic test_basic();
    int n, f, hs, dc; logic [63:0] la;
    run_job(64'h1000, 36'd64, 36'h100, 3, 8'h5A, 100, 4, 0, n, f, hs, dc, la);
    total++;
    if (n != 3) begin bad++; $display("FAIL basic_cmd_count got=%0d want=3", n); end
    total++;
    if (la !== 64'h1200) begin bad++; $display("FAIL basic_last_addr got=%h want=1200", la); end
  endtask

  task automatic test_credit();
    int n, f, hs, dc; logic [63:0] la;
    run_job(64'h4000, 36'd32, 36'h40, 8, 8'h11, 100, 1, 20, n, f, hs, dc, la);
    total++;
    if (f != MAX) begin bad++; $display("FAIL credit_before_done got=%0d want=%0d", f, MAX); end
    total++;
    if (n != 8) begin bad++; $display("FAIL credit_cmd_count got=%0d want=8", n); end
  endtask

  task automatic test_random_accept();
    int n, f, hs, dc, cnt; logic [63:0] la;
    for (int j = 0; j < 4; j++) begin
      cnt = $urandom_range(20, 1);
      run_job({$urandom, $urandom}, 36'({$urandom, $urandom}), 36'({$urandom, $urandom}), cnt,
              8'($urandom), 50, $urandom_range(6, 1), 0, n, f, hs, dc, la);
      total++;
      if (n != cnt) begin bad++; $display("FAIL random_cmd_count job=%0d got=%0d want=%0d", j, n, cnt); end
    end
  endtask

  task automatic test_zero_rows();
    int n, f, hs, dc; logic [63:0] la;
    run_job(64'h8000, 36'd16, 36'h10, 0, 8'h22, 100, 2, 0, n, f, hs, dc, la);
    total++;
    if (n != 0) begin bad++; $display("FAIL zero_cmd_count got=%0d want=0", n); end
    total++;
    if (dc != hs + 1) begin bad++; $display("FAIL zero_done_latency got=%0d want=%0d", dc - hs, 1); end
  endtask

  task automatic test_wrap();
    int n, f, hs, dc; logic [63:0] la;
    run_job(64'hFFFF_FFFF_FFFF_FF80, 36'd128, 36'h100, 2, 8'h33, 100, 3, 0, n, f, hs, dc, la);
    total++;
    if (la !== 64'h0000_0000_0000_0080) begin bad++; $display("FAIL wrap_addr got=%h want=0000000000000080", la); end
  endtask

  task automatic test_error_flag();
    @(negedge clk);
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
    total++;
    if (error !== ERR_EXP) begin bad++; $display("FAIL error_set got=%b want=%b", error, ERR_EXP); end
    repeat (3) @(negedge clk);
    total++;
    if (error !== ERR_EXP || job_busy !== 1'b0) begin
      bad++; $display("FAIL error_hold got=%b busy=%b want=%b busy=0", error, job_busy, ERR_EXP);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL error_clear got=%b want=0", error); end
  endtask

  task automatic test_reset_mid_job();
    int n, f, hs, dc; logic [63:0] la;
    bit saw_done;
    @(negedge clk);
    job_valid = 1'b1; job_base_addr = 64'hA000; job_row_len = 36'd8; job_row_stride = 36'h8;
    job_row_count = 12'd8; job_id = 8'h44;
    @(negedge clk);
    job_valid = 1'b0; cmd_accept = 1'b1;
    repeat (2) @(negedge clk);
    cmd_accept = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if ({job_accept, cmd_valid, job_busy, job_done, error} !== 5'b0 || cmd_payload !== '0) begin
      bad++; $display("FAIL midjob_reset got=%b pl=%h want=00000 pl=0", {job_accept, cmd_valid, job_busy, job_done, error}, cmd_payload);
    end
    rst = 1'b0;
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (job_done) saw_done = 1;
    end
    total++;
    if (saw_done || job_accept !== 1'b1) begin
      bad++; $display("FAIL midjob_after got=done%b acc%b want=done0 acc1", saw_done, job_accept);
    end
    run_job(64'hB000, 36'd8, 36'h8, 6, 8'h45, 100, 5, 0, n, f, hs, dc, la);
    total++;
    if (n != 6) begin bad++; $display("FAIL post_reset_cmd_count got=%0d want=6", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_random_accept();
    test_zero_rows();
    test_wrap();
    test_error_flag();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
